// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, arbiter state and timeout default for alu_req_arbiter
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam int TIMEOUT_CYCLES_DEFAULT = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; ptr = 1 favours requester 1 on contention
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic ptr;
  always_comb begin
    grant[0] = en && valid[0] && (!valid[1] || !ptr);
    grant[1] = en && valid[1] && (!valid[0] || ptr);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= 1'b0;
    else if (|grant) ptr <= grant[0];
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU between two requesters with round-robin arbitration.
// Define ALU_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES without alu_done.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [1:0]  req1_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err
);
  arb_state_t state, state_nx;
  logic [1:0] grant;
  logic accept, sel, div0, timeout;
  logic [7:0] sel_a, sel_b;
  logic [1:0] sel_op;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .en    (state == IDLE),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign accept = |grant;
  assign sel    = grant[1];
  assign sel_a  = sel ? req1_a : req0_a;
  assign sel_b  = sel ? req1_b : req0_b;
  assign sel_op = sel ? req1_op : req0_op;
  assign div0   = sel_op == OP_DIV && sel_b == 8'd0;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (state == ISSUE) cnt <= '0;
    else if (state == WAIT) cnt <= cnt + CW'(1);
  // alu_done on the last allowed WAIT cycle still wins over the abort
  assign timeout = state == WAIT && !alu_done && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (div0 ? RESP : ISSUE) : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (alu_done || timeout) ? RESP : WAIT;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    alu_start  = state == ISSUE;
    rsp_valid  = state == RESP;
    req0_ready = grant[0];
    req1_ready = grant[1];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      alu_a    <= sel_a;
      alu_b    <= sel_b;
      alu_op   <= sel_op;
      rsp_id   <= sel;
      rsp_data <= div0 ? 16'hFFFF : 16'h0000;
      rsp_err  <= div0;
    end else if (state == WAIT && (alu_done || timeout)) begin
      rsp_data <= alu_done ? alu_result : 16'h0000;
      rsp_err  <= !alu_done;
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: randomized and directed checks against a timestamp-based transaction model
module tb_alu_req_arbiter;
  import alu_pkg::*;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 32;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [1:0] req0_op, req1_op, alu_op;
  logic alu_start, alu_done, rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] alu_result, rsp_data;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit active = 0, favor = 0, div0 = 0, junk = 0, inject = 0;
  int t_start = -10, t_done = -10, t_resp = -10, force_d = -1;
  logic [7:0] ea, eb;
  logic [1:0] eop;
  logic eid, eerr;
  logic [15:0] edata;
  int ids[$];
  int t0;

  alu_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_result(alu_result), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    if (op == OP_ADD) return {8'h0, a} + {8'h0, b};
    if (op == OP_SUB) return {8'h0, a} - {8'h0, b};
    if (op == OP_MUL) return {8'h0, a} * {8'h0, b};
    return b == 8'd0 ? 16'hFFFF : {8'h0, a} / {8'h0, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_req(input bit v0, input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] o0,
                         input bit v1, input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] o1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
  endtask

  // One clock: drive the ALU, compare outputs with the model, advance the model, end at next negedge.
  task automatic step();
    logic g0, g1, rv;
    int d;
    alu_done = inject || (active && !div0 && (cyc == t_done || (junk && cyc == t_start)));
    alu_result = (active && !div0 && cyc == t_done) ? edata : 16'($urandom);
    #1;
    rv = active && cyc >= t_resp;
    chk("alu_start", alu_start, active && !div0 && cyc == t_start);
    chk("rsp_valid", rsp_valid, rv);
    if (rv) begin
      chk("rsp_id", rsp_id, eid);
      chk("rsp_data", rsp_data, edata);
      chk("rsp_err", rsp_err, eerr);
    end
    if (active && !div0 && cyc >= t_start && cyc < t_resp) begin
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_op", alu_op, eop);
    end
    g0 = !active && req0_valid && (!req1_valid || !favor);
    g1 = !active && req1_valid && (!req0_valid || favor);
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    if (rv && rsp_ready) active = 0;
    else if (g0 || g1) begin
      active = 1;
      eid = g1;
      ea = g1 ? req1_a : req0_a;
      eb = g1 ? req1_b : req0_b;
      eop = g1 ? req1_op : req0_op;
      favor = !g1;
      div0 = eop == OP_DIV && eb == 8'd0;
      if (div0) begin
        t_resp = cyc + 1; edata = 16'hFFFF; eerr = 1'b1;
      end else begin
        t_start = cyc + 1;
        junk = 1'($urandom_range(1, 0));
        d = force_d >= 0 ? force_d : int'($urandom_range(4, 1));
        if (d == 0) begin
          t_done = -10; t_resp = t_start + TO + 1; edata = 16'h0; eerr = 1'b1;
        end else begin
          t_done = t_start + d; t_resp = t_done + 1; edata = ref_alu(ea, eb, eop); eerr = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; alu_done = 1'b0; rsp_ready = 1'b0; inject = 0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_ctl", {req0_ready, req1_ready, alu_start, rsp_valid, rsp_id, rsp_err}, 0);
    chk("reset_alu", {alu_a, alu_b, alu_op}, 0);
    chk("reset_data", rsp_data, 0);
    active = 0; favor = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && active; i++) step();
    chk("drained", active, 0);
  endtask

  initial begin
    alu_done = 1'b0; alu_result = '0; rsp_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // both requesters continuously valid: grants alternate starting from req0
    rsp_ready = 1'b1;
    for (int i = 0; i < 80 && ids.size() < 4; i++) begin
      set_req(1, 8'($urandom), 8'($urandom_range(255, 1)), 2'($urandom),
              1, 8'($urandom), 8'($urandom_range(255, 1)), 2'($urandom));
      if (rsp_valid) ids.push_back(int'(rsp_id));
      step();
    end
    chk("alt_count", ids.size(), 4);
    foreach (ids[i]) chk($sformatf("alt_id%0d", i), ids[i], i % 2);
    drain();

    // req0 ADD 5,3 with ALU done one cycle after start
    force_d = 1;
    set_req(1, 8'd5, 8'd3, OP_ADD, 0, 0, 0, 0);
    step();
    force_d = -1;
    req0_valid = 1'b0;
    chk("add_start_t1", alu_start, 1);
    step();
    chk("add_rv_t2", rsp_valid, 0);
    step();
    chk("add_rv_t3", rsp_valid, 1);
    chk("add_data", rsp_data, 16'd8);
    chk("add_id", rsp_id, 0);
    chk("add_err", rsp_err, 0);
    step();

    // req1 divide by zero short-circuits the ALU
    set_req(0, 0, 0, 0, 1, 8'd9, 8'd0, OP_DIV);
    step();
    req1_valid = 1'b0;
    chk("div0_start", alu_start, 0);
    chk("div0_rv_t1", rsp_valid, 1);
    chk("div0_data", rsp_data, 16'hFFFF);
    chk("div0_err", rsp_err, 1);
    chk("div0_id", rsp_id, 1);
    step();

    // response backpressure for 4 cycles while both requesters wait
    force_d = 2;
    rsp_ready = 1'b0;
    set_req(1, 8'd20, 8'd7, OP_SUB, 0, 0, 0, 0);
    step();
    force_d = -1;
    set_req(1, 8'd1, 8'd2, OP_ADD, 1, 8'd3, 8'd4, OP_MUL);
    for (int i = 0; i < 10 && !rsp_valid; i++) step();
    chk("hold_reach", rsp_valid, 1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_data", rsp_data, 16'd13);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("hold_idle_rv", rsp_valid, 0);
    step();
    drain();

    // reset during WAIT discards the MUL; the late alu_done must not produce a response
    force_d = 3;
    set_req(1, 8'd12, 8'd10, OP_MUL, 0, 0, 0, 0);
    step();
    force_d = -1;
    req0_valid = 1'b0;
    step();
    step();
    do_reset();
    rsp_ready = 1'b1;
    inject = 1;
    step();
    inject = 0;
    for (int i = 0; i < 4; i++) step();
    chk("late_done_rv", rsp_valid, 0);

`ifdef ALU_ARB_TIMEOUT_EN
    // ALU never answers: abort after TIMEOUT_CYCLES WAIT cycles, later done ignored
    force_d = 0;
    rsp_ready = 1'b0;
    set_req(1, 8'd7, 8'd7, OP_ADD, 0, 0, 0, 0);
    t0 = cyc;
    step();
    force_d = -1;
    req0_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    chk("to_latency", cyc - t0, 6);
    chk("to_data", rsp_data, 16'h0);
    chk("to_err", rsp_err, 1);
    inject = 1;
    step();
    inject = 0;
    drain();
`endif

    // random traffic with random backpressure, ALU latency and dropped requests
    for (int i = 0; i < 600; i++) begin
      set_req($urandom_range(9, 0) < 6, 8'($urandom), ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom), 2'($urandom),
              $urandom_range(9, 0) < 6, 8'($urandom), ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom), 2'($urandom));
      rsp_ready = $urandom_range(9, 0) < 7;
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 32, meaning the maximum number of WAIT cycles before abort (used only when ALU_ARB_TIMEOUT_EN is defined).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports reqN_valid  input  1  request valid from requester N (N = 0, 1).
REQ-005 The block SHALL have ports reqN_ready  output  1  request accepted when high together with reqN_valid.
REQ-006 The block SHALL have ports reqN_a, reqN_b  input  8  operands, and reqN_op  input  2  operation (00 ADD, 01 SUB, 10 MUL, 11 DIV).
REQ-007 The block SHALL have ports alu_a, alu_b  output  8  and alu_op  output  2  registered operands and operation driven to the shared ALU.
REQ-008 The block SHALL have port alu_start  output  1  one-cycle start pulse to the ALU.
REQ-009 The block SHALL have ports alu_result  input  16  and alu_done  input  1  ALU result and completion.
REQ-010 The block SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (granted requester), rsp_data  output  16, rsp_err  output  1.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-012 In IDLE, the block SHALL assert reqN_ready combinationally for exactly one valid requester, chosen round-robin; with both requesters valid, the requester not granted last wins.
REQ-013 The block SHALL deassert both reqN_ready outside IDLE.
REQ-014 On accept, the block SHALL register operands, op and id into alu_a/alu_b/alu_op/rsp_id, then transition IDLE->ISSUE.
REQ-015 If the accepted op is DIV with b = 0, the block SHALL skip the ALU, load rsp_data = 16'hFFFF and rsp_err = 1, and transition IDLE->RESP.
REQ-016 In ISSUE, the block SHALL assert alu_start for exactly one cycle and transition ISSUE->WAIT.
REQ-017 alu_done sampled during ISSUE SHALL be ignored.
REQ-018 In WAIT, when alu_done = 1, the block SHALL capture alu_result into rsp_data with rsp_err = 0 and transition WAIT->RESP.
REQ-019 In RESP, the block SHALL hold rsp_valid = 1 with rsp_id, rsp_data and rsp_err stable until rsp_ready = 1, then transition RESP->IDLE.
REQ-020 The round-robin pointer SHALL update on accept, to favour the other requester.
REQ-021 Timing SHALL be: accept at cycle T, alu_start at T+1, and rsp_valid on the cycle after alu_done is sampled.
REQ-022 Minimum accept-to-rsp_valid latency SHALL be 3 cycles (ALU done at T+2); the div-by-zero path SHALL give rsp_valid at T+1.
REQ-023 alu_a, alu_b and alu_op SHALL remain stable from ISSUE through WAIT.
REQ-024 A requester deasserting valid before it is granted SHALL lose no state; requests are not queued.

Reset
REQ-025 On reset, the block SHALL enter IDLE and discard any in-flight operation; a late alu_done SHALL be ignored.
REQ-026 On reset, all outputs SHALL be 0, and the round-robin pointer SHALL favour req0.

Configuration
REQ-027 With ALU_ARB_TIMEOUT_EN defined, a WAIT cycle counter SHALL clear on ISSUE; if it reaches TIMEOUT_CYCLES without alu_done, the block SHALL go to RESP with rsp_data = 0 and rsp_err = 1, and ignore any later alu_done for that operation.
REQ-028 Without ALU_ARB_TIMEOUT_EN, the block SHALL wait in WAIT indefinitely, the counter SHALL be absent, and rsp_err SHALL be set only by divide-by-zero.

Structure
REQ-029 Shared package alu_pkg SHALL hold op encoding constants (ADD/SUB/MUL/DIV), the arbiter state enum and the TIMEOUT_CYCLES default.
REQ-030 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant and pointer.

Verification
REQ-031 Bench SHALL cover: req0 ADD 5,3 with ALU done at T+2 -> alu_start at T+1; rsp_valid at T+3 with rsp_data = 8, rsp_id = 0, rsp_err = 0.
REQ-032 Bench SHALL cover: req0 and req1 valid continuously -> grants alternate 0,1,0,1; the responses' rsp_id follows the same order.
REQ-033 Bench SHALL cover: req1 DIV 9,0 -> no alu_start; rsp_valid at T+1 with rsp_data = FFFF, rsp_err = 1.
REQ-034 Bench SHALL cover: rsp_ready held low for 4 cycles -> rsp outputs stable, both reqN_ready low, then IDLE the cycle after rsp_ready.
REQ-035 Bench SHALL cover: reset asserted in WAIT (MUL 12,10) -> IDLE, all outputs 0; alu_done afterwards produces no response.
REQ-036 Bench SHALL cover, with ALU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4: alu_done never arrives -> rsp_err = 1, rsp_data = 0 after 4 WAIT cycles.
